// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and
// the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_LW    = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0001;
  localparam logic [3:0] OP_J     = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1001;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned JT_MSB  = 11;
  localparam int unsigned JT_LSB  = 0;
  localparam int unsigned FT_MSB  = 7;
  localparam int unsigned FT_LSB  = 0;
  localparam int unsigned JT_W    = JT_MSB - JT_LSB + 1;
  localparam int unsigned FT_W    = FT_MSB - FT_LSB + 1;

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch stage: absolute jump, relative branch or
// sequential, all modulo 2^PC_W.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 12
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [JT_W-1:0] ir_lo_i,
  input  logic            seljump_i,
  input  logic            selbr_i,
  output logic [PC_W-1:0] pc_next_o
);

  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] pc_plus1;

  // Branch offset is the signed low byte; the jump target is zero-extended.
  assign jump_tgt = PC_W'(ir_lo_i);
  assign br_off   = PC_W'(signed'(ir_lo_i[FT_MSB:FT_LSB]));
  assign pc_plus1 = pc_i + PC_W'(1);

  always_comb begin
    pc_next_o = pc_plus1;
    if (seljump_i) begin
      pc_next_o = jump_tgt;
    end else if (selbr_i) begin
      pc_next_o = pc_plus1 + br_off;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: requests an instruction, holds it in the IR for one
// EXEC window, then advances the PC from the controller's jump/branch decision.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 12,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               hold,
  input  logic               seljump,
  input  logic               selbr,
  output logic               instr_valid,
  output logic [3:0]         opcode,
  output logic [FT_W-1:0]    func_type,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   retired
);

  logic [0:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [PC_W-1:0]    pc_next;

  pc_next_calc #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc_i      (pc_q),
    .ir_lo_i   (ir_q[JT_MSB:JT_LSB]),
    .seljump_i (seljump),
    .selbr_i   (selbr),
    .pc_next_o (pc_next)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      default: begin
        if (!hold) begin
          pc_d      = pc_next;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Gating with rst drops the request in the same cycle reset is asserted.
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC);
  assign opcode      = ir_q[OP_MSB:OP_LSB];
  assign func_type   = ir_q[FT_MSB:FT_LSB];
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of fetch records plus
// hand-written reset sequences; fetch addresses are checked via a scoreboard.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        hold;
  logic        seljump;
  logic        selbr;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [7:0]  func_type;
  logic [11:0] pc;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .PC_W     (12),
    .INSTR_W  (16),
    .RESET_PC (12'h000),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .hold        (hold),
    .seljump     (seljump),
    .selbr       (selbr),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .func_type   (func_type),
    .pc          (pc),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          ack_delay;
    int          hold_cycles;
    logic        sj;
    logic        sb;
    logic [11:0] exp_next;
  } fetch_vec_t;

  fetch_vec_t  vecs[14];
  logic [11:0] addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] exp_addr;
    logic [15:0] prev_word;
    logic [15:0] exp_ret;

    //           word      dly hold sj    sb    next
    vecs[0]  = '{16'h8011, 0, 0, 1'b0, 1'b0, 12'h001};
    vecs[1]  = '{16'h0022, 0, 0, 1'b0, 1'b0, 12'h002};
    vecs[2]  = '{16'h1033, 0, 0, 1'b0, 1'b0, 12'h003};
    vecs[3]  = '{16'h2005, 4, 0, 1'b1, 1'b0, 12'h005};
    vecs[4]  = '{16'h20A3, 0, 0, 1'b1, 1'b0, 12'h0A3};
    vecs[5]  = '{16'h200A, 1, 0, 1'b1, 1'b0, 12'h00A};
    vecs[6]  = '{16'h40FC, 0, 0, 1'b0, 1'b1, 12'h007};
    vecs[7]  = '{16'h200A, 0, 0, 1'b1, 1'b0, 12'h00A};
    vecs[8]  = '{16'h20FC, 0, 0, 1'b1, 1'b1, 12'h0FC};
    vecs[9]  = '{16'h4030, 0, 3, 1'b0, 1'b0, 12'h0FD};
    vecs[10] = '{16'h2FFF, 2, 0, 1'b1, 1'b0, 12'hFFF};
    vecs[11] = '{16'h8000, 0, 0, 1'b0, 1'b0, 12'h000};
    vecs[12] = '{16'h4080, 0, 0, 1'b0, 1'b1, 12'hF81};
    vecs[13] = '{16'h407F, 0, 1, 1'b0, 1'b1, 12'h001};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    hold = 1'b0; seljump = 1'b0; selbr = 1'b0;
    tick(); tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_retired", retired, 0);
    check("rst_opcode", opcode, 0);
    check("rst_functype", func_type, 0);
    rst = 1'b0;
    addr_q.push_back(12'h000);
    tick();

    prev_word = '0;
    exp_ret   = '0;
    for (int i = 0; i < 14; i++) begin
      if (addr_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
        exp_addr = '0;
      end else begin
        exp_addr = addr_q.pop_front();
      end
      imem_ack = 1'b0;
      check("req_valid_low", instr_valid, 0);
      for (int d = 0; d < vecs[i].ack_delay; d++) begin
        check("wait_req", imem_req, 1);
        check("wait_addr", imem_addr, exp_addr);
        check("wait_ir_stable", opcode, prev_word[15:12]);
        tick();
      end
      check("req", imem_req, 1);
      check("fetch_addr", imem_addr, exp_addr);
      imem_ack   = 1'b1;
      imem_rdata = vecs[i].word;
      tick();
      // ack kept high with garbage data during EXEC; it must be ignored
      imem_rdata = ~vecs[i].word;
      for (int h = 0; h <= vecs[i].hold_cycles; h++) begin
        check("exec_valid", instr_valid, 1);
        check("exec_req", imem_req, 0);
        check("exec_opcode", opcode, vecs[i].word[15:12]);
        check("exec_functype", func_type, vecs[i].word[7:0]);
        check("exec_pc", pc, exp_addr);
        check("exec_retired", retired, exp_ret);
        if (h < vecs[i].hold_cycles) begin
          hold = 1'b1; seljump = 1'b1; selbr = 1'b1;
        end else begin
          hold = 1'b0; seljump = vecs[i].sj; selbr = vecs[i].sb;
          addr_q.push_back(vecs[i].exp_next);
          exp_ret++;
        end
        tick();
      end
      seljump = 1'b0; selbr = 1'b0; imem_ack = 1'b0;
      prev_word = vecs[i].word;
    end

    // Reset pulse in the middle of S_REQ
    exp_addr = addr_q.pop_front();
    check("final_addr", imem_addr, exp_addr);
    check("final_retired", retired, exp_ret);
    tick();
    #2 rst = 1'b1;
    #1;
    check("midreq_rst_req", imem_req, 0);
    check("midreq_rst_pc", pc, 0);
    check("midreq_rst_retired", retired, 0);
    check("midreq_rst_opcode", opcode, 0);
    tick();
    rst = 1'b0;
    tick();
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 12'h000);

    // Reset pulse in the middle of S_EXEC
    imem_ack = 1'b1; imem_rdata = 16'h8055;
    tick();
    imem_ack = 1'b0;
    check("pre_rst_valid", instr_valid, 1);
    check("pre_rst_opcode", opcode, 4'h8);
    #2 rst = 1'b1;
    #1;
    check("midexec_rst_valid", instr_valid, 0);
    check("midexec_rst_retired", retired, 0);
    check("midexec_rst_opcode", opcode, 0);
    check("midexec_rst_req", imem_req, 0);
    tick();
    rst = 1'b0;
    tick();
    check("restart2_req", imem_req, 1);
    check("restart2_addr", imem_addr, 12'h000);
    check("restart2_retired", retired, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
